// File: rtl/terminal_access_arbiter.sv
// Two-terminal (LEDS / MATRIZ) access arbiter with per-channel authentication and round-robin grants.
// Optional deny lockout is enabled by defining DENY_LOCKOUT_EN.
module terminal_access_arbiter #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     req_valid,
  input  logic [3*N_CH-1:0]   req_code,
  input  logic [3*N_CH-1:0]   req_func,
  input  logic [N_CH-1:0]     req_term,
  input  logic [55:0]         perm_table,
  output logic [N_CH-1:0]     req_ack,
  output logic [N_CH-1:0]     req_deny,
  output logic [N_CH-1:0]     locked,
  output logic                led_valid,
  output logic [2:0]          led_func,
  output logic [2:0]          led_owner,
  output logic                mat_valid,
  output logic [2:0]          mat_func,
  output logic [2:0]          mat_owner
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  if (N_CH < 2 || N_CH > 8 || HOLD_CYCLES < 1 || LOCK_CYCLES < 1) begin : g_param_chk
    $error("terminal_access_arbiter: illegal parameter value");
  end

  logic [N_CH-1:0][2:0] w_code;
  logic [N_CH-1:0][2:0] w_fn;
  logic [N_CH-1:0][5:0] w_pidx;
  logic [N_CH-1:0]      w_perm;
  logic [N_CH-1:0]      w_armed;
  logic [N_CH-1:0]      w_locked;
  logic [N_CH-1:0]      w_deny_c;
  logic [N_CH-1:0]      w_ack_c;
  logic [N_CH-1:0]      w_grant_led;
  logic [N_CH-1:0]      w_grant_mat;
  logic [N_CH-1:0]      r_ack;
  logic [N_CH-1:0]      r_deny;
  logic [N_CH-1:0]      r_consumed;

  // Per-channel decode: permission lookup into the 7-bit mask of the presented code
  for (genvar g = 0; g < N_CH; g++) begin : g_dec
    assign w_code[g] = req_code[3*g +: 3];
    assign w_fn[g]   = req_func[3*g +: 3];
    assign w_pidx[g] = 6'(7 * 32'(w_code[g]) + 32'(w_fn[g]));
    assign w_perm[g] = (w_fn[g] != 3'd7) && perm_table[w_pidx[g]];
  end

  assign w_armed  = req_valid & ~r_consumed & ~w_locked;
  assign w_deny_c = w_armed & ~w_perm;
  assign w_ack_c  = w_grant_led | w_grant_mat;

  // First candidate at or after ptr, wrapping modulo N_CH
  function automatic logic [2:0] rr_pick(input logic [N_CH-1:0] cand, input logic [2:0] ptr);
    logic [2:0]      win;
    logic            hit;
    logic [N_CH-1:0] sh;
    int unsigned     k;
    win = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      k = 32'(ptr) + i;
      if (k >= N_CH) k = k - N_CH;
      sh = cand >> k;
      if (!hit && sh[0]) begin
        hit = 1'b1;
        win = 3'(k);
      end
    end
    return win;
  endfunction

  for (genvar t = 0; t < 2; t++) begin : g_term
    state_t          r_state, w_state_nx;
    logic [HW-1:0]   r_cnt, w_cnt_nx;
    logic [2:0]      r_ptr, w_ptr_nx;
    logic [2:0]      r_func, w_func_nx;
    logic [2:0]      r_owner, w_owner_nx;
    logic            r_valid, w_valid_nx;
    logic [N_CH-1:0] w_cand;
    logic [N_CH-1:0] w_grant;
    logic [2:0]      w_win;
    logic            w_hit;

    if (t == 0) begin : g_led
      assign w_cand      = w_armed & w_perm & ~req_term;
      assign w_grant_led = w_grant;
      assign led_valid   = r_valid;
      assign led_func    = r_func;
      assign led_owner   = r_owner;
    end else begin : g_mat
      assign w_cand      = w_armed & w_perm & req_term;
      assign w_grant_mat = w_grant;
      assign mat_valid   = r_valid;
      assign mat_func    = r_func;
      assign mat_owner   = r_owner;
    end

    assign w_win = rr_pick(w_cand, r_ptr);
    assign w_hit = |w_cand;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_ptr   <= '0;
        r_func  <= '0;
        r_owner <= '0;
        r_valid <= 1'b0;
      end else begin
        r_state <= w_state_nx;
        r_cnt   <= w_cnt_nx;
        r_ptr   <= w_ptr_nx;
        r_func  <= w_func_nx;
        r_owner <= w_owner_nx;
        r_valid <= w_valid_nx;
      end
    end

    // Grant only from IDLE; HOLD counts down and always leaves one IDLE cycle behind it
    always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_ptr_nx   = r_ptr;
      w_func_nx  = r_func;
      w_owner_nx = r_owner;
      w_valid_nx = r_valid;
      w_grant    = '0;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            w_grant    = {{(N_CH-1){1'b0}}, 1'b1} << w_win;
            w_state_nx = S_HOLD;
            w_cnt_nx   = HW'(HOLD_CYCLES);
            w_valid_nx = 1'b1;
            w_func_nx  = w_fn[w_win];
            w_owner_nx = w_win;
            w_ptr_nx   = (w_win == 3'(N_CH - 1)) ? 3'd0 : w_win + 3'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == HW'(1)) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
            w_valid_nx = 1'b0;
          end else begin
            w_cnt_nx = r_cnt - HW'(1);
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_valid_nx = 1'b0;
        end
      endcase
    end
  end

  // Response pulses and consumed flags; a request re-arms only after req_valid drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack      <= '0;
      r_deny     <= '0;
      r_consumed <= '0;
    end else begin
      r_ack      <= w_ack_c;
      r_deny     <= w_deny_c;
      r_consumed <= req_valid & (r_consumed | w_ack_c | w_deny_c);
    end
  end

  assign req_ack  = r_ack;
  assign req_deny = r_deny;

`ifdef DENY_LOCKOUT_EN
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

  logic [N_CH-1:0]         r_locked;
  logic [N_CH-1:0][1:0]    r_dcnt;
  logic [N_CH-1:0][LW-1:0] r_lcnt;

  // Third consecutive deny locks the channel out; ack or lock expiry resets the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked <= '0;
      r_dcnt   <= '0;
      r_lcnt   <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (r_locked[c]) begin
          if (r_lcnt[c] == LW'(1)) begin
            r_locked[c] <= 1'b0;
            r_lcnt[c]   <= '0;
            r_dcnt[c]   <= '0;
          end else begin
            r_lcnt[c] <= r_lcnt[c] - LW'(1);
          end
        end else if (w_ack_c[c]) begin
          r_dcnt[c] <= '0;
        end else if (w_deny_c[c]) begin
          if (r_dcnt[c] == 2'd2) begin
            r_locked[c] <= 1'b1;
            r_lcnt[c]   <= LW'(LOCK_CYCLES);
            r_dcnt[c]   <= 2'd3;
          end else begin
            r_dcnt[c] <= r_dcnt[c] + 2'd1;
          end
        end
      end
    end
  end

  assign w_locked = r_locked;
`else
  assign w_locked = '0;
`endif

  assign locked = w_locked;

endmodule
